// File: rtl/turn_ctrl_pkg.sv
// Shared types, piece codes and packet helpers for the turn controller.
// The initial chess position is built here so reset and new_game agree.
package turn_ctrl_pkg;

  typedef enum logic [1:0] {
    TITLE_SCREEN,
    CHESS_SCREEN,
    OVER_SCREEN
  } screen_state_t;

  typedef enum logic [1:0] {
    WAIT_LOCAL,
    WAIT_REMOTE,
    TX
  } turn_state_t;

  typedef logic [3:0]             piece_t;
  typedef logic [11:0]            packet_t;
  typedef logic [7:0][7:0][3:0]   board_t;

  localparam piece_t PIECE_EMPTY = 4'd15;
  localparam piece_t W_PAWN      = 4'd5;
  localparam piece_t W_QUEEN     = 4'd3;
  localparam piece_t B_PAWN      = 4'd11;
  localparam piece_t B_QUEEN     = 4'd9;

  function automatic logic [2:0] src_x(input packet_t p);
    return p[11:9];
  endfunction

  function automatic logic [2:0] src_y(input packet_t p);
    return p[8:6];
  endfunction

  function automatic logic [2:0] dst_x(input packet_t p);
    return p[5:3];
  endfunction

  function automatic logic [2:0] dst_y(input packet_t p);
    return p[2:0];
  endfunction

  // White owns 0-5, black owns 6-11; 12-15 belong to nobody.
  function automatic logic is_colour(
    input piece_t p,
    input logic   c
  );
    if (c) return p <= 4'd5;
    return (p >= 4'd6) && (p <= 4'd11);
  endfunction

  function automatic piece_t promote(
    input piece_t     p,
    input logic [2:0] dx
  );
    if (p == W_PAWN && dx == 3'd0) return W_QUEEN;
    if (p == B_PAWN && dx == 3'd7) return B_QUEEN;
    return p;
  endfunction

  function automatic piece_t back_rank(input logic [2:0] y);
    piece_t p;
    case (y)
      3'd0, 3'd7: p = 4'd0;
      3'd1, 3'd6: p = 4'd1;
      3'd2, 3'd5: p = 4'd2;
      3'd3:       p = 4'd3;
      default:    p = 4'd4;
    endcase
    return p;
  endfunction

  function automatic board_t init_board();
    board_t b;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) b[x][y] = PIECE_EMPTY;
      b[0][y] = back_rank(3'(y)) + 4'd6;
      b[1][y] = B_PAWN;
      b[6][y] = W_PAWN;
      b[7][y] = back_rank(3'(y));
    end
    return b;
  endfunction

  localparam board_t INIT_BOARD = init_board();

endpackage

// File: rtl/turn_ctrl_apply.sv
// Combinational move check and board rewrite, shared by the
// local and remote move paths.
module move_apply
  import turn_ctrl_pkg::*;
(
  input  board_t  board,
  input  packet_t packet,
  input  logic    colour,
  output logic    valid,
  output board_t  next_board
);

  logic [2:0] sx, sy, dx, dy;
  piece_t     src_p, dst_p;

  assign sx    = src_x(packet);
  assign sy    = src_y(packet);
  assign dx    = dst_x(packet);
  assign dy    = dst_y(packet);
  assign src_p = board[sx][sy];
  assign dst_p = board[dx][dy];

  assign valid = is_colour(src_p, colour)
              && (packet[11:6] != packet[5:0])
              && ((dst_p == PIECE_EMPTY)
               || is_colour(dst_p, !colour));

  always_comb begin
    next_board         = board;
    next_board[dx][dy] = promote(src_p, dx);
    next_board[sx][sy] = PIECE_EMPTY;
  end

endmodule

// File: rtl/turn_ctrl.sv
// Owns the board and turn token, applies local/remote moves and
// forwards local moves to the serial link.
module turn_ctrl
  import turn_ctrl_pkg::*;
#(
  parameter int TX_TIMEOUT = 50_000_000,
  parameter int CNT_W      = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  screen_state_t    sys_state,
  input  logic             player,
  input  logic             new_game,
  input  logic             local_moved,
  input  packet_t          local_packet,
  input  logic             rx_valid,
  input  packet_t          rx_packet,
  output logic             tx_valid,
  output packet_t          tx_packet,
  input  logic             tx_ready,
  output board_t           stable_board,
  output logic             curr_player,
  output logic             move_err,
  output logic             link_err,
  output logic [CNT_W-1:0] move_count
);

  localparam int TO_W = $clog2(TX_TIMEOUT + 1);
  typedef logic [TO_W-1:0] to_cnt_t;
  localparam to_cnt_t TO_MAX = to_cnt_t'(TX_TIMEOUT);

  turn_state_t      state;
  to_cnt_t          to_cnt, to_cnt_n;
  board_t           board_n, mv_board;
  packet_t          mv_packet, tx_packet_n;
  logic             mv_valid;
  logic             player_n, tx_valid_n;
  logic             move_err_n, link_err_n;
  logic [CNT_W-1:0] count_n, count_inc;

  // TX is exactly "a packet is held"; otherwise the token decides.
  assign state = tx_valid ? TX
               : (curr_player == player) ? WAIT_LOCAL
               : WAIT_REMOTE;

  assign mv_packet = (state == WAIT_LOCAL) ? local_packet : rx_packet;
  assign count_inc = (move_count == '1) ? move_count
                   : move_count + CNT_W'(1);

  move_apply u_apply (
    .board      (stable_board),
    .packet     (mv_packet),
    .colour     (curr_player),
    .valid      (mv_valid),
    .next_board (mv_board)
  );

  always_comb begin
    board_n     = stable_board;
    player_n    = curr_player;
    tx_valid_n  = tx_valid;
    tx_packet_n = tx_packet;
    move_err_n  = 1'b0;
    link_err_n  = link_err;
    count_n     = move_count;
    to_cnt_n    = to_cnt;
    if (sys_state == CHESS_SCREEN) begin
      if (new_game) begin
        board_n     = INIT_BOARD;
        player_n    = 1'b1;
        tx_valid_n  = 1'b0;
        tx_packet_n = '0;
        link_err_n  = 1'b0;
        count_n     = '0;
        to_cnt_n    = '0;
      end else begin
        unique case (state)
          WAIT_LOCAL: begin
            if (local_moved) begin
              if (mv_valid) begin
                board_n     = mv_board;
                tx_packet_n = local_packet;
                tx_valid_n  = 1'b1;
                count_n     = count_inc;
                to_cnt_n    = '0;
              end else begin
                move_err_n = 1'b1;
              end
            end else if (rx_valid) begin
              move_err_n = 1'b1;
            end
          end
          WAIT_REMOTE: begin
            if (rx_valid) begin
              if (mv_valid) begin
                board_n  = mv_board;
                count_n  = count_inc;
                player_n = ~curr_player;
              end else begin
                move_err_n = 1'b1;
              end
            end
          end
          TX: begin
            if (tx_ready) begin
              tx_valid_n = 1'b0;
              player_n   = ~curr_player;
              to_cnt_n   = '0;
            end else if (to_cnt != TO_MAX) begin
              to_cnt_n = to_cnt + to_cnt_t'(1);
              if (to_cnt == TO_MAX - to_cnt_t'(1))
                link_err_n = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      stable_board <= INIT_BOARD;
      curr_player  <= 1'b1;
      tx_valid     <= 1'b0;
      tx_packet    <= '0;
      move_err     <= 1'b0;
      link_err     <= 1'b0;
      move_count   <= '0;
      to_cnt       <= '0;
    end else begin
      stable_board <= board_n;
      curr_player  <= player_n;
      tx_valid     <= tx_valid_n;
      tx_packet    <= tx_packet_n;
      move_err     <= move_err_n;
      link_err     <= link_err_n;
      move_count   <= count_n;
      to_cnt       <= to_cnt_n;
    end
  end

endmodule
